// File: rtl/neural_pkg.sv
// neural_pkg: shared constants, FSM state and sample types, saturation helper for the neural signal synth
package neural_pkg;
  localparam int BIN_LEN = 1500;
  localparam int TMPL_LEN = 32;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t SPIKE = 1'b1;
  typedef logic signed [15:0] sample_t;
  function automatic sample_t sat16(input logic signed [16:0] x);
    return (x > 17'sd32767) ? 16'sh7fff : (x < -17'sd32768) ? 16'sh8000 : x[15:0];
  endfunction
endpackage

// File: rtl/spike_template_rom.sv
// spike_template_rom: 32-entry biphasic spike template, registered read (clk, idx[4:0] -> sample s16)
module spike_template_rom
  import neural_pkg::*;
(
  input  logic    clk,
  input  logic [4:0] idx,
  output sample_t sample
);
  localparam sample_t ROM [TMPL_LEN] = '{
    16'sd0,     -16'sd100,  -16'sd300,  -16'sd700,  -16'sd1200, -16'sd1700, -16'sd2000, -16'sd1800,
    -16'sd1400, -16'sd900,  -16'sd400,  16'sd0,     16'sd300,   16'sd600,   16'sd800,   16'sd750,
    16'sd650,   16'sd550,   16'sd450,   16'sd380,   16'sd310,   16'sd250,   16'sd200,   16'sd150,
    16'sd110,   16'sd80,    16'sd55,    16'sd35,    16'sd20,    16'sd10,    16'sd5,     16'sd0
  };
  always_ff @(posedge clk) sample <= ROM[idx];
endmodule

// File: rtl/neural_signal_synth.sv
// neural_signal_synth: velocity-driven spike train synth (clk, rst, vel_in/vel_valid -> raw_out, spike_flag, bin_strobe, bin_count, drop_flag)
module neural_signal_synth #(
  parameter int BIN_LEN    = neural_pkg::BIN_LEN,
  parameter int BASE_COUNT = 10,
  parameter int GAIN_SHIFT = 6,
  parameter int MAX_COUNT  = 40,
  parameter int NOISE_EN   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] vel_in,
  input  logic               vel_valid,
  output logic signed [15:0] raw_out,
  output logic               spike_flag,
  output logic               bin_strobe,
  output logic [5:0]         bin_count,
  output logic               drop_flag
);
  import neural_pkg::*;
  logic [15:0] bin_timer, phase_acc, lfsr;
  logic first, fire, start;
  logic signed [15:0] vel_pending;
  state_t state;
  logic [4:0] tmpl_idx, rom_idx;
  sample_t rom_q, tmpl, noise;
  logic signed [16:0] cnt_raw, sum;
  logic [5:0] cnt_new;
  logic [16:0] acc_next;
  spike_template_rom u_rom (.clk(clk), .idx(rom_idx), .sample(rom_q));
  always_comb begin
    start = first | (bin_timer == 16'(BIN_LEN - 1));
    cnt_raw = 17'(BASE_COUNT) + 17'(vel_pending >>> GAIN_SHIFT);
    cnt_new = cnt_raw[16] ? 6'd0 : (cnt_raw > 17'(MAX_COUNT)) ? 6'(MAX_COUNT) : cnt_raw[5:0];
    acc_next = {1'b0, phase_acc} + {11'd0, bin_count};
    fire = acc_next >= 17'(BIN_LEN);
    spike_flag = fire && state == IDLE;
    rom_idx = state == SPIKE ? tmpl_idx + 5'd1 : 5'd0;
    tmpl = state == SPIKE ? rom_q : 16'sd0;
    noise = NOISE_EN != 0 ? $signed({{8{lfsr[7]}}, lfsr[7:0]}) >>> 2 : 16'sd0;
    sum = 17'(tmpl) + 17'(noise);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_timer <= '0;
      phase_acc <= '0;
      first <= 1'b1;
      vel_pending <= '0;
      state <= IDLE;
      tmpl_idx <= '0;
      lfsr <= LFSR_SEED;
      bin_strobe <= 1'b0;
      bin_count <= '0;
      drop_flag <= 1'b0;
      raw_out <= '0;
    end else begin
      first <= 1'b0;
      bin_timer <= start ? '0 : bin_timer + 16'd1;
      bin_strobe <= start;
      bin_count <= start ? cnt_new : bin_count;
      phase_acc <= start ? '0 : fire ? 16'(acc_next - 17'(BIN_LEN)) : acc_next[15:0];
      vel_pending <= vel_valid ? vel_in : vel_pending;
      state <= state == IDLE ? (fire ? SPIKE : IDLE) : (tmpl_idx == 5'd31 ? IDLE : SPIKE);
      tmpl_idx <= state == SPIKE ? tmpl_idx + 5'd1 : 5'd0;
      drop_flag <= drop_flag | (fire && state == SPIKE);
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
      raw_out <= sat16(sum);
    end
  end
endmodule

// File: doc/neural_signal_synth.md
NEURAL_SIGNAL_SYNTH -- requirements
Module: neural_signal_synth

Interface
REQ-001 Parameter BIN_LEN, default 1500: samples per bin; the pipeline's bin period.
REQ-002 Parameter BASE_COUNT, default 10: spikes per bin at zero velocity.
REQ-003 Parameter GAIN_SHIFT, default 6: velocity-to-count shift; count offset = vel >>> GAIN_SHIFT.
REQ-004 Parameter MAX_COUNT, default 40: upper clamp on spikes per bin.
REQ-005 Parameter NOISE_EN, default 1: 0 disables the noise adder, so output is deterministic.
REQ-006 clk  in  1: sample clock; all logic on its rising edge.
REQ-007 rst  in  1: reset, synchronous, active-high.
REQ-008 vel_in  in  16 signed: commanded velocity.
REQ-009 vel_valid  in  1: one-cycle strobe that captures vel_in.
REQ-010 raw_out  out  16 signed: synthetic neural sample, one per clk.
REQ-011 spike_flag  out  1: one-cycle pulse on each spike onset.
REQ-012 bin_strobe  out  1: one-cycle pulse at each bin start.
REQ-013 bin_count  out  6: spike count target in force for the current bin.
REQ-014 drop_flag  out  1: sticky flag; set when a spike onset collides with an active waveform.

Function
REQ-015 The vel_pending register SHALL load vel_in on any cycle in which vel_valid=1; the last strobe before a bin boundary wins.
REQ-016 The bin_timer SHALL count 0..BIN_LEN-1 and then wrap to 0.
REQ-017 On each wrap, and on the first cycle after reset, bin_strobe SHALL pulse for 1 cycle.
REQ-018 On the same cycle as bin_strobe, bin_count SHALL load clamp(BASE_COUNT + (vel_pending >>> GAIN_SHIFT), 0, MAX_COUNT), computed in 17-bit signed arithmetic.
REQ-019 On the same cycle as bin_strobe, phase_acc SHALL clear to 0.
REQ-020 Each cycle, acc_next = phase_acc + bin_count.
- If acc_next >= BIN_LEN, a spike SHALL fire and phase_acc <= acc_next - BIN_LEN.
- Otherwise phase_acc <= acc_next.
REQ-021 A bin SHALL therefore contain exactly bin_count spikes, at bin_timer = k*BIN_LEN/bin_count - 1 for k = 1..bin_count (integer division, count>0).
REQ-022 bin_count = 0 SHALL produce no spikes in that bin.
REQ-023 Waveform FSM states SHALL be IDLE and SPIKE:
- IDLE -> SPIKE on fire, with tmpl_idx = 0 and spike_flag = 1 that cycle.
- In SPIKE, tmpl_idx increments every cycle.
- SPIKE -> IDLE after tmpl_idx = 31.
REQ-024 A fire while in SPIKE SHALL be dropped: no restart, no spike_flag, and drop_flag set until reset.
REQ-025 The template sample SHALL be ROM[tmpl_idx] while in SPIKE and 0 in IDLE.
REQ-026 ROM[0] SHALL appear on raw_out 2 cycles after spike_flag (1 ROM read + 1 output register).
REQ-027 Noise SHALL come from a 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1, advancing every cycle.
REQ-028 noise = sign-extended lfsr[7:0] >>> 2 when NOISE_EN=1, else 0.
REQ-029 raw_out SHALL be registered saturate16(template + noise), clamped to [-32768, 32767].
REQ-030 The ROM SHALL be a 32-entry signed biphasic template with minimum -2000 at index 6, maximum +800 at index 14, and 0 at indices 0 and 31.

Reset
REQ-031 Under rst, the following SHALL clear to 0 on the next edge: raw_out, spike_flag, bin_strobe, bin_count, drop_flag, bin_timer, phase_acc, tmpl_idx, and vel_pending. The FSM SHALL go to IDLE.
REQ-032 Under rst, the LFSR SHALL reload 16'hACE1.
REQ-033 Reset mid-spike SHALL abort the waveform; raw_out SHALL be 0 on the cycle after rst is sampled.
REQ-034 vel_valid during rst SHALL be ignored.

Structure
REQ-035 The shared package neural_pkg SHALL hold:
- BIN_LEN, TMPL_LEN=32, LFSR_SEED and LFSR_TAPS;
- the FSM state typedef;
- the sample typedef (signed 16).
REQ-036 The ROM SHALL be a sub-module spike_template_rom: input idx 5 bits, output sample signed 16, 1-cycle registered read.
REQ-037 The expected implementation size is roughly 150-250 lines of RTL plus a ROM of about 50 lines.

Verification
REQ-038 NOISE_EN=0, vel_in=0 -> bin_count=10; spike_flag at bin_timer 149, 299, ..., 1499; 10 spikes per bin.
REQ-039 vel_in=640, strobed mid-bin -> current bin unchanged; the next bin_strobe loads bin_count=20 and the bin contains 20 spikes spaced 75 apart.
REQ-040 vel_in=-1000 -> bin_count=0 and no spike_flag for the full bin; vel_in=32767 -> bin_count=40 with drop_flag still 0.
REQ-041 NOISE_EN=0, one spike -> raw_out 2 cycles after spike_flag reproduces ROM[0..31]: -2000 at offset +8, +800 at offset +16, 0 elsewhere in IDLE.
REQ-042 Force a fire during SPIKE (bin_count forced to 63 via test parameter) -> the second spike_flag is suppressed, drop_flag=1, and the waveform is not truncated.
REQ-043 Assert rst at tmpl_idx=10 -> next cycle all outputs are 0, the LFSR is 16'hACE1, and the first post-reset cycle has bin_strobe=1 with bin_count=10.
